shared_dmem_resp: RTL
=====================

SHARED_DMEM_RESP -- requirements
Module: shared_dmem_resp

Interface
REQ-001 SHALL have parameter NCORES, default 4, number of requesting cores.
REQ-002 SHALL have parameter ADDRW, default 14, word-address width; memory depth 2^ADDRW 32-bit words.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port re_packed_i  input  NCORES  per-core read request.
REQ-006 SHALL have port we_packed_i  input  NCORES  per-core write request.
REQ-007 SHALL have port addr_packed_i  input  ADDRW*NCORES  word address, lane i at [ADDRW*(i+1)-1:ADDRW*i].
REQ-008 SHALL have port wdata_packed_i  input  32*NCORES  write data per lane.
REQ-009 SHALL have port wstrb_packed_i  input  4*NCORES  byte strobes per lane, bit b enables byte b.
REQ-010 SHALL have port is_lr_packed_i  input  NCORES  read is load-reserved.
REQ-011 SHALL have port is_sc_packed_i  input  NCORES  write is store-conditional.
REQ-012 SHALL have port rdata_packed_o  output  32*NCORES  per-core read/SC result.
REQ-013 SHALL have port stall_packed_o  output  NCORES  per-core stall.

Function
REQ-014 Request from core i SHALL be re[i]|we[i]; re and we never both high; core holds all lane inputs stable while stall[i]=1.
REQ-015 At most one request SHALL be granted per cycle (single-port array).
REQ-016 stall_packed_o[i] SHALL be combinational: req[i] & ~grant[i]; 0 when no request.
REQ-017 Grant SHALL be round-robin: search starts at pointer rr; after a grant to core g, rr <= (g+1) mod NCORES; rr unchanged in idle cycles.
REQ-018 Granted read SHALL update rdata lane i at the next rising edge with mem[addr]; lane holds its value until core i's next granted read or SC.
REQ-019 Granted write SHALL update only bytes with wstrb=1; rdata lane unchanged for plain writes.
REQ-020 Granted read with is_lr SHALL set rsv_valid[i]=1, rsv_addr[i]=addr (overwriting any prior reservation).
REQ-021 Granted SC SHALL succeed iff rsv_valid[i] & rsv_addr[i]==addr: success writes memory and rdata lane i <= 0; failure writes nothing and rdata lane i <= 1; either way rsv_valid[i] <= 0.
REQ-022 Any memory-modifying write (plain or successful SC) to address A SHALL clear rsv_valid[j] for every core j with rsv_addr[j]==A, including the writer.
REQ-023 Read-after-write to same address in consecutive grants SHALL return new data (no bypass needed: write commits before next grant's read).
REQ-024 Memory contents SHALL NOT be reset and are undefined at power-up.

Reset
REQ-025 While rst_ni=0: no grant, stall_packed_o = req, no memory write.
REQ-026 On rst_ni falling edge, immediately: rdata_packed_o=0, all rsv_valid=0, rr=0; a read granted in the cycle before reset produces no data.
REQ-027 First grant after rst_ni rises SHALL occur in the same cycle the request is present.

Configuration
REQ-028 Macro SHARED_DMEM_RR_EN defined: round-robin arbitration per REQ-017.
REQ-029 SHARED_DMEM_RR_EN undefined: fixed priority, lowest requesting index wins every cycle; rr register absent; all else identical.

Verification
REQ-030 Core0 write addr 5 data 0xDEADBEEF wstrb 4'hF, then read addr 5 -> stall[0]=0 both cycles, lane0 = 0xDEADBEEF one cycle after read.
REQ-031 Write 0x11223344 to addr 3, then 0xAABBCCDD wstrb 4'b0010, read -> 0x1122CC44.
REQ-032 RR on, rr=0, cores 0-3 read addrs 0-3 same cycle -> grants 0,1,2,3 on consecutive cycles; core3 stalled 3 cycles; rr ends at 0.
REQ-033 Core0 LR addr 8; core1 writes 0x55 to addr 8; core0 SC 0x77 addr 8 -> lane0=1, mem[8]=0x55; repeat LR/SC without intervening write -> lane0=0, mem[8]=0x77.
REQ-034 Core0 LR addr 8, assert rst_ni=0 mid-stall of core2 -> rdata all 0 immediately; after release core0 SC addr 8 -> lane0=1, no write.
REQ-035 RR off, cores 0 and 2 request continuously for 5 cycles -> core0 granted every cycle, stall[2]=1 throughout.

Source files
------------

// File: rtl/shared_dmem_resp.sv
// shared_dmem_resp: N-core front end to one single-port 32-bit data memory.
// It arbitrates between the cores, handles byte-strobed writes, and tracks
// one load-reserved/store-conditional (LR/SC) reservation per core.
// It grants at most one access per cycle. A granted read or SC result
// appears on the core's rdata lane at the next rising edge.
// Configuration macro SHARED_DMEM_RR_EN:
//   defined   -> round-robin arbitration. The search starts at pointer rr,
//                which moves past each granted core.
//   undefined -> fixed priority. The lowest requesting core wins, and there
//                is no rr register.
module shared_dmem_resp #(
  parameter int NCORES = 4,
  parameter int ADDRW  = 14
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NCORES-1:0]       re_packed_i,
  input  logic [NCORES-1:0]       we_packed_i,
  input  logic [ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]    wdata_packed_i,
  input  logic [4*NCORES-1:0]     wstrb_packed_i,
  input  logic [NCORES-1:0]       is_lr_packed_i,
  input  logic [NCORES-1:0]       is_sc_packed_i,
  output logic [32*NCORES-1:0]    rdata_packed_o,
  output logic [NCORES-1:0]       stall_packed_o
);

  localparam int IDXW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int DEPTH = 1 << ADDRW;

  // Storage array; deliberately never reset
  logic [31:0]       mem [DEPTH];

  // Per-lane views of the packed buses
  logic [ADDRW-1:0]  addr_lane  [NCORES];
  logic [31:0]       wdata_lane [NCORES];
  logic [3:0]        wstrb_lane [NCORES];
  logic [31:0]       rdata_lane [NCORES];

  // Reservation state
  logic [NCORES-1:0] rsv_valid;
  logic [ADDRW-1:0]  rsv_addr [NCORES];

  // Arbitration
  logic [NCORES-1:0] req;
  logic [NCORES-1:0] grant;
  logic              pick_found;

  // Granted access, muxed out of the winning lane
  logic              gnt_we;
  logic              gnt_sc;
  logic [ADDRW-1:0]  gnt_addr;
  logic [31:0]       gnt_wdata;
  logic [3:0]        gnt_wstrb;
  logic              gnt_rsv_valid;
  logic [ADDRW-1:0]  gnt_rsv_addr;
  logic              sc_ok;
  logic              mem_we;
  logic [31:0]       rd_word;

`ifdef SHARED_DMEM_RR_EN
  logic [IDXW-1:0]   rr;
`endif

  // Split the packed lane buses into per-core arrays
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      addr_lane[i]  = addr_packed_i[i*ADDRW +: ADDRW];
      wdata_lane[i] = wdata_packed_i[i*32 +: 32];
      wstrb_lane[i] = wstrb_packed_i[i*4 +: 4];
    end
  end

  assign req = re_packed_i | we_packed_i;

  // Pick at most one requester. There are no grants while reset is held.
  always_comb begin
    grant      = '0;
    pick_found = 1'b0;
    if (rst_ni) begin
`ifdef SHARED_DMEM_RR_EN
      // First pass: cores at or above the pointer
      for (int i = 0; i < NCORES; i++) begin
        if (!pick_found && req[i] && (IDXW'(i) >= rr)) begin
          grant[i]   = 1'b1;
          pick_found = 1'b1;
        end
      end
`endif
      // Wrap-around pass (or the only pass in fixed priority): lowest index wins
      for (int i = 0; i < NCORES; i++) begin
        if (!pick_found && req[i]) begin
          grant[i]   = 1'b1;
          pick_found = 1'b1;
        end
      end
    end
  end

  assign stall_packed_o = req & ~grant;

  // Route the granted lane's request fields to the single memory port
  always_comb begin
    gnt_we        = 1'b0;
    gnt_sc        = 1'b0;
    gnt_addr      = '0;
    gnt_wdata     = '0;
    gnt_wstrb     = '0;
    gnt_rsv_valid = 1'b0;
    gnt_rsv_addr  = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (grant[i]) begin
        gnt_we        = we_packed_i[i];
        gnt_sc        = is_sc_packed_i[i];
        gnt_addr      = addr_lane[i];
        gnt_wdata     = wdata_lane[i];
        gnt_wstrb     = wstrb_lane[i];
        gnt_rsv_valid = rsv_valid[i];
        gnt_rsv_addr  = rsv_addr[i];
      end
    end
  end

  // An SC only commits when the writer still holds a reservation on that exact word
  assign sc_ok   = gnt_we & gnt_sc & gnt_rsv_valid & (gnt_rsv_addr == gnt_addr);
  assign mem_we  = gnt_we & (~gnt_sc | sc_ok);
  assign rd_word = mem[gnt_addr];

  // Byte-strobed memory write. A write commits at this edge, so a read
  // granted in the following cycle sees the new word without bypassing.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (gnt_wstrb[b]) mem[gnt_addr][8*b +: 8] <= gnt_wdata[8*b +: 8];
      end
    end
  end

  // Per-core result lanes: read data, or the SC status (0 = success, 1 = failure)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCORES; i++) rdata_lane[i] <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (grant[i]) begin
          if (re_packed_i[i]) begin
            rdata_lane[i] <= rd_word;
          end else if (is_sc_packed_i[i]) begin
            rdata_lane[i] <= sc_ok ? 32'd0 : 32'd1;
          end
        end
      end
    end
  end

  // Reservation valid flags: set by LR, consumed by SC, and killed by any
  // committed write to the reserved word (including the core's own write)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv_valid <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (grant[i] && re_packed_i[i] && is_lr_packed_i[i]) begin
          rsv_valid[i] <= 1'b1;
        end else if (grant[i] && we_packed_i[i] && is_sc_packed_i[i]) begin
          rsv_valid[i] <= 1'b0;
        end else if (mem_we && (rsv_addr[i] == gnt_addr)) begin
          rsv_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Reserved address; only meaningful while the matching valid flag is set
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCORES; i++) begin
      if (grant[i] && re_packed_i[i] && is_lr_packed_i[i]) rsv_addr[i] <= addr_lane[i];
    end
  end

`ifdef SHARED_DMEM_RR_EN
  // Round-robin pointer: move just past the core that was granted; hold when idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (grant[i]) rr <= (i == NCORES - 1) ? '0 : IDXW'(i + 1);
      end
    end
  end
`endif

  // Pack the result lanes back onto the output bus
  always_comb begin
    rdata_packed_o = '0;
    for (int i = 0; i < NCORES; i++) rdata_packed_o[i*32 +: 32] = rdata_lane[i];
  end

endmodule
